// File: rtl/fft_pkg.sv
// Shared definitions for the frame deserializer: parameter defaults,
// the per-bank fill state and a bit-reversal helper for index mapping.
package fft_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH = 16;
  localparam int unsigned DEF_PART_WIDTH   = 16;
  localparam int unsigned DEF_NUM_POINTS   = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Reverse the low 'bits' bits of 'value'.
  function automatic int unsigned bitrev(input int unsigned value,
                                         input int unsigned bits);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      result = (result << 1) | ((value >> i) & 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/deser_bank.sv
// One frame-storage bank.
//   clk      : rising-edge clock
//   clear    : synchronous clear of the whole bank (wins over a write)
//   we       : write one part of one point
//   wr_point : point index to write
//   wr_imag  : 1 = imag (lower) part, 0 = real (upper) part
//   wr_data  : part value, already sign-extended
//   rd_data  : full parallel read, point k at [(k+1)*2*PART_WIDTH-1 -: 2*PART_WIDTH]
module deser_bank
  import fft_pkg::*;
#(
  parameter int unsigned PART_WIDTH = DEF_PART_WIDTH,
  parameter int unsigned NUM_POINTS = DEF_NUM_POINTS,
  localparam int unsigned IDX_W      = $clog2(NUM_POINTS),
  localparam int unsigned WORD_WIDTH = 2 * PART_WIDTH,
  localparam int unsigned OUT_WIDTH  = NUM_POINTS * WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_point,
  input  logic                  wr_imag,
  input  logic [PART_WIDTH-1:0] wr_data,
  output logic [OUT_WIDTH-1:0]  rd_data
);

  logic [OUT_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      data_q <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < NUM_POINTS; k++) begin
        if (wr_point == IDX_W'(k)) begin
          if (wr_imag) data_q[k*WORD_WIDTH +: PART_WIDTH] <= wr_data;
          else         data_q[k*WORD_WIDTH + PART_WIDTH +: PART_WIDTH] <= wr_data;
        end
      end
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame deserializer with ping-pong banks.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data : serial sample stream (signed samples)
//   real_mode    : 1 = one real sample per point, 0 = real then imag
//   frame_abort  : pulse discarding the partially filled frame
//   out_valid/out_ready/out_data : packed frame output
//   out_real     : real_mode latched for the presented frame
module frame_deserializer
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned PART_WIDTH   = DEF_PART_WIDTH,
  parameter int unsigned NUM_POINTS   = DEF_NUM_POINTS,
  parameter int unsigned BIT_REVERSE  = 0,
  localparam int unsigned WORD_WIDTH  = 2 * PART_WIDTH,
  localparam int unsigned OUT_WIDTH   = NUM_POINTS * WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    real_mode,
  input  logic                    frame_abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_real
);

  localparam int unsigned IDX_W = $clog2(NUM_POINTS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_REAL = CNT_W'(NUM_POINTS - 1);
  localparam logic [CNT_W-1:0] LAST_CPLX = CNT_W'(2 * NUM_POINTS - 1);

  bank_state_t          state_q [2];
  bank_state_t          state_d [2];
  logic                 fill_sel_q;
  logic                 out_sel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 frame_real_q;
  logic [1:0]           real_lat_q;

  logic                 accept;
  logic                 xfer;
  logic                 write;
  logic                 beat_real;
  logic                 last_beat;
  logic [IDX_W-1:0]     point;
  logic [IDX_W-1:0]     wr_idx;
  logic                 wr_imag;
  logic [PART_WIDTH-1:0] wr_data;
  logic [1:0]           bank_clr;
  logic [1:0]           bank_we;
  logic [OUT_WIDTH-1:0] bank_rd [2];

  // Beat decode. The frame's mode is taken live on its first beat and from
  // the latched copy afterwards, so mid-frame toggles of real_mode are ignored.
  always_comb begin
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    write     = accept && !frame_abort;
    beat_real = (cnt_q == '0) ? real_mode : frame_real_q;
    last_beat = beat_real ? (cnt_q == LAST_REAL) : (cnt_q == LAST_CPLX);
    point     = beat_real ? cnt_q[IDX_W-1:0] : cnt_q[IDX_W:1];
    wr_imag   = !beat_real && cnt_q[0];
    wr_data   = PART_WIDTH'($signed(in_data));
    wr_idx    = point;
    if (BIT_REVERSE != 0) wr_idx = IDX_W'(bitrev(32'(point), IDX_W));
  end

  // Banks are cleared whenever they return to EMPTY, so imag parts never
  // written in real mode read as zero.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      bank_clr[b] = reset
                 || (xfer && out_sel_q == 1'(b))
                 || (frame_abort && fill_sel_q == 1'(b) && state_q[b] == BANK_FILLING);
      bank_we[b]  = write && fill_sel_q == 1'(b);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    deser_bank #(
      .PART_WIDTH (PART_WIDTH),
      .NUM_POINTS (NUM_POINTS)
    ) u_bank (
      .clk      (clk),
      .clear    (bank_clr[b]),
      .we       (bank_we[b]),
      .wr_point (wr_idx),
      .wr_imag  (wr_imag),
      .wr_data  (wr_data),
      .rd_data  (bank_rd[b])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0]   <= BANK_EMPTY;
      state_q[1]   <= BANK_EMPTY;
      fill_sel_q   <= 1'b0;
      out_sel_q    <= 1'b0;
      cnt_q        <= '0;
      frame_real_q <= 1'b0;
      real_lat_q   <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      if (xfer) out_sel_q <= !out_sel_q;
      if (frame_abort) begin
        cnt_q <= '0;
      end else if (accept) begin
        frame_real_q           <= beat_real;
        real_lat_q[fill_sel_q] <= beat_real;
        if (last_beat) begin
          cnt_q      <= '0;
          fill_sel_q <= !fill_sel_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Next-state logic. The filling bank is never FULL while accepting and the
  // presenting bank is FULL while transferring, so the two updates never
  // target the same bank.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (xfer) state_d[out_sel_q] = BANK_EMPTY;
    if (frame_abort) begin
      if (state_q[fill_sel_q] == BANK_FILLING) state_d[fill_sel_q] = BANK_EMPTY;
    end else if (accept) begin
      state_d[fill_sel_q] = last_beat ? BANK_FULL : BANK_FILLING;
    end
  end

  // Outputs, from registered state only.
  always_comb begin
    in_ready  = (state_q[fill_sel_q] != BANK_FULL);
    out_valid = (state_q[out_sel_q] == BANK_FULL);
    out_data  = out_valid ? bank_rd[out_sel_q] : '0;
    out_real  = out_valid && real_lat_q[out_sel_q];
  end

endmodule
